// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Instruction-fetch front end of a 5-stage ARM-style pipeline. It holds the
// PC, fetches one instruction word at a time from instruction memory over a
// variable-latency req/ack handshake, and drives the IF/ID pipeline register
// (instruction, PC+4, valid) consumed by the decode stage.
//
// The unit honours a freeze (hazard stall) from the hazard-detection logic.
// It also honours a redirect from a taken branch resolved in EXE.
//
// Ports
//   clk          : clock, all state changes on the rising edge
//   rst          : synchronous active-high reset
//   freeze       : hazard stall; hold IF/ID and do not advance
//   branch_taken : redirect request, sampled every edge
//   branch_addr  : redirect target, valid with branch_taken
//   imem_req     : fetch request to instruction memory
//   imem_addr    : fetch address, stable while a request is pending
//   imem_ack     : response valid (may arrive in the same cycle as imem_req)
//   imem_rdata   : instruction word, valid with imem_ack
//   instruction  : IF/ID instruction word
//   pc_out       : IF/ID PC+4 of that instruction
//   valid        : IF/ID holds a real instruction (0 = bubble)
//
// Control states
//   ST_REQ   : a request to req_addr is on the bus every cycle.
//   ST_DROP  : a branch arrived while a request was in flight. The old
//              request must still complete, because only one transaction
//              may be outstanding. Its data is thrown away and the
//              redirect target is parked in pc until the ack arrives.
//   ST_STALL : a word arrived while frozen. It is parked in the skid
//              registers and no new request is issued until the freeze
//              lifts, so nothing can be lost.
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_INC   = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic [31:0] pc_out,
    output logic        valid
);

    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_DROP  = 2'd1,
        ST_STALL = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic        valid_q, valid_d;

    // Sequential successor of the address in flight. The addition is 32-bit
    // modulo, so 0xFFFF_FFFC wraps to 0 without any flag.
    logic [31:0] seq_addr;
    assign seq_addr = req_addr_q + PC_INC;

    // -----------------------------------------------------------------------
    // Next-state logic. Every branch starts from "hold everything". Branch
    // handling is always tested before freeze, so a redirect kills the IF/ID
    // entry even while the pipeline is frozen.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_addr_d   = req_addr_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        instr_d      = instr_q;
        pc_out_d     = pc_out_q;
        valid_d      = valid_q;

        unique case (state_q)
            ST_REQ: begin
                if (imem_ack) begin
                    if (branch_taken) begin
                        // Word just fetched is on the wrong path: drop it and
                        // restart at the target next cycle.
                        pc_d       = branch_addr;
                        req_addr_d = branch_addr;
                        valid_d    = 1'b0;
                    end else if (freeze) begin
                        // Decode cannot take the word yet; park it and stop
                        // issuing until the freeze lifts.
                        skid_instr_d = imem_rdata;
                        skid_pc_d    = seq_addr;
                        pc_d         = seq_addr;
                        req_addr_d   = seq_addr;
                        state_d      = ST_STALL;
                    end else begin
                        instr_d    = imem_rdata;
                        pc_out_d   = seq_addr;
                        valid_d    = 1'b1;
                        pc_d       = seq_addr;
                        req_addr_d = seq_addr;
                    end
                end else if (branch_taken) begin
                    // Request still in flight, so req_addr must not move.
                    // Remember the target and wait out the old transaction.
                    pc_d    = branch_addr;
                    valid_d = 1'b0;
                    state_d = ST_DROP;
                end else if (!freeze) begin
                    // Decode consumed the current entry and nothing new has
                    // arrived: present a bubble, keeping the stale payload.
                    valid_d = 1'b0;
                end
            end

            ST_DROP: begin
                valid_d = 1'b0;
                if (branch_taken) begin
                    pc_d = branch_addr;
                end
                if (imem_ack) begin
                    // Discard the stale word and aim at the newest target,
                    // including one that arrives on this very edge.
                    req_addr_d = branch_taken ? branch_addr : pc_q;
                    state_d    = ST_REQ;
                end
            end

            ST_STALL: begin
                if (branch_taken) begin
                    // The parked word is on the wrong path as well.
                    pc_d       = branch_addr;
                    req_addr_d = branch_addr;
                    valid_d    = 1'b0;
                    state_d    = ST_REQ;
                end else if (!freeze) begin
                    instr_d  = skid_instr_q;
                    pc_out_d = skid_pc_q;
                    valid_d  = 1'b1;
                    state_d  = ST_REQ;
                end
            end

            default: begin
                state_d = ST_REQ;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers. Reset abandons any outstanding request; the memory
    // side sees imem_req drop and must tolerate it.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_REQ;
            pc_q         <= RESET_PC;
            req_addr_q   <= RESET_PC;
            skid_instr_q <= 32'h0;
            skid_pc_q    <= 32'h0;
            instr_q      <= 32'h0;
            pc_out_q     <= 32'h0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_addr_q   <= req_addr_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            instr_q      <= instr_d;
            pc_out_q     <= pc_out_d;
            valid_q      <= valid_d;
        end
    end

    // A request is on the bus in every state except STALL. It is gated by
    // reset so memory never sees a request while the unit is being cleared.
    assign imem_req    = (state_q != ST_STALL) && !rst;
    assign imem_addr   = req_addr_q;
    assign instruction = instr_q;
    assign pc_out      = pc_out_q;
    assign valid       = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//
// Bench for fetch_unit. A behavioural instruction memory with programmable
// latency answers requests; each word is a fixed function of its address.
//
// Expected IF/ID entries are queued as each scenario is set up. They are
// popped whenever decode would consume an entry, which is on an edge where
// valid=1, freeze=0, no branch and no reset. Direct checks cover the
// cycle-level behaviour of each scenario.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        freeze = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_addr = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic [31:0] pc_out;
    logic        valid;

    int n_checks = 0;
    int n_errors = 0;

    fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .PC_INC   (32'd4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .instruction  (instruction),
        .pc_out       (pc_out),
        .valid        (valid)
    );

    always #5 clk = ~clk;

    // ---------------- instruction memory model ----------------
    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return addr ^ 32'hE1A0_0000;
    endfunction

    int unsigned mem_lat  = 0;   // extra wait cycles before ack
    int unsigned wait_cnt = 0;

    assign imem_ack   = imem_req && (wait_cnt >= mem_lat);
    assign imem_rdata = imem_ack ? mem_word(imem_addr) : 32'hDEAD_BEEF;

    always @(posedge clk) begin
        if (!imem_req || imem_ack) wait_cnt <= 0;
        else                       wait_cnt <= wait_cnt + 1;
    end

    // ---------------- checking ----------------
    task automatic check32(input string tag, input logic [31:0] actual,
                           input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic check_entry(input string tag, input logic [31:0] addr);
        check32({tag, "_instr"}, instruction, mem_word(addr));
        check32({tag, "_pcout"}, pc_out, addr + 32'd4);
        check32({tag, "_valid"}, {31'h0, valid}, 32'd1);
    endtask

    task automatic check_bubble(input string tag);
        check32({tag, "_valid"}, {31'h0, valid}, 32'd0);
    endtask

    // ---------------- scoreboard ----------------
    logic [63:0] sb_q[$];

    task automatic expect_entry(input logic [31:0] addr);
        sb_q.push_back({mem_word(addr), addr + 32'd4});
    endtask

    logic        pend_prev = 1'b0;
    logic [31:0] addr_prev = 32'h0;

    always @(negedge clk) begin
        logic [63:0] exp_e;
        if (!rst) begin
            if (valid && !freeze && !branch_taken) begin
                check32("sb_avail", {31'h0, sb_q.size() > 0}, 32'd1);
                if (sb_q.size() > 0) begin
                    exp_e = sb_q.pop_front();
                    $display("ifid consume instr=0x%08h pc_out=0x%08h (exp 0x%08h/0x%08h)",
                             instruction, pc_out, exp_e[63:32], exp_e[31:0]);
                    check32("sb_instr", instruction, exp_e[63:32]);
                    check32("sb_pcout", pc_out, exp_e[31:0]);
                end
            end
            // Address must not move while a request waits for its ack.
            if (pend_prev && imem_req)
                check32("addr_stable", imem_addr, addr_prev);
            pend_prev = imem_req && !imem_ack;
            addr_prev = imem_addr;
        end else begin
            pend_prev = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        // Reset state
        repeat (3) step();
        check32("rst_instr", instruction, 32'h0);
        check32("rst_pcout", pc_out, 32'h0);
        check32("rst_valid", {31'h0, valid}, 32'd0);
        check32("rst_req", {31'h0, imem_req}, 32'd0);
        check32("rst_addr", imem_addr, 32'h0);

        // 1: zero-wait sequential fetch
        expect_entry(32'h0); expect_entry(32'h4); expect_entry(32'h8);
        rst = 1'b0; #1;
        check32("t1_req", {31'h0, imem_req}, 32'd1);
        check32("t1_addr0", imem_addr, 32'h0);
        step(); check_entry("t1_e0", 32'h0); check32("t1_addr4", imem_addr, 32'h4);
        step(); check_entry("t1_e4", 32'h4); check32("t1_addr8", imem_addr, 32'h8);
        step(); check_entry("t1_e8", 32'h8); check32("t1_addr12", imem_addr, 32'hC);

        // 2: two wait cycles -> bubble pattern 0,0,1
        mem_lat = 2; expect_entry(32'hC);
        step(); check_bubble("t2_b0"); check32("t2_hold0", imem_addr, 32'hC);
        step(); check_bubble("t2_b1"); check32("t2_hold1", imem_addr, 32'hC);
        step(); check_entry("t2_e12", 32'hC); check32("t2_next", imem_addr, 32'h10);

        // 3: freeze while the ack for 0x10 arrives
        freeze = 1'b1; expect_entry(32'h10);
        step(); check_entry("t3_hold0", 32'hC);
        step(); check_entry("t3_hold1", 32'hC);
        step(); check_entry("t3_hold2", 32'hC);
        check32("t3_noreq0", {31'h0, imem_req}, 32'd0);
        step(); check_entry("t3_hold3", 32'hC);
        check32("t3_noreq1", {31'h0, imem_req}, 32'd0);
        step(); check_entry("t3_hold4", 32'hC);
        check32("t3_noreq2", {31'h0, imem_req}, 32'd0);
        freeze = 1'b0;
        step(); check_entry("t3_rel", 32'h10);
        check32("t3_addr", imem_addr, 32'h14);
        check32("t3_req", {31'h0, imem_req}, 32'd1);

        // 4: branch while the request to 0x20 is outstanding
        mem_lat = 0; expect_entry(32'h14); expect_entry(32'h18);
        step(); check_entry("t4_e14", 32'h14);
        step(); check_entry("t4_e18", 32'h18);
        step(); check_entry("t4_e1c", 32'h1C); check32("t4_addr20", imem_addr, 32'h20);
        mem_lat = 3; branch_taken = 1'b1; branch_addr = 32'h100;
        step(); check_bubble("t4_kill"); check32("t4_inflight", imem_addr, 32'h20);
        branch_taken = 1'b0;
        step(); check_bubble("t4_drop0");
        step(); check_bubble("t4_drop1");
        step(); check_bubble("t4_drop2"); check32("t4_redir", imem_addr, 32'h100);
        mem_lat = 0;
        step(); check_entry("t4_e100", 32'h100);

        // 5: branch together with freeze while in STALL
        freeze = 1'b1;
        step(); check_entry("t5_frz", 32'h100);
        check32("t5_stall", {31'h0, imem_req}, 32'd0);
        branch_taken = 1'b1; branch_addr = 32'h40;
        step(); check_bubble("t5_kill");
        check32("t5_addr", imem_addr, 32'h40);
        check32("t5_req", {31'h0, imem_req}, 32'd1);
        freeze = 1'b0; branch_taken = 1'b0; expect_entry(32'h40);
        step(); check_entry("t5_e40", 32'h40);

        // 6: reset mid-wait, restart, PC wrap
        mem_lat = 5;
        step(); check_bubble("t6_wait"); check32("t6_addr44", imem_addr, 32'h44);
        rst = 1'b1; #1;
        check32("t6_rstreq", {31'h0, imem_req}, 32'd0);
        step(); step();
        check32("t6_instr", instruction, 32'h0);
        check32("t6_pcout", pc_out, 32'h0);
        check32("t6_valid", {31'h0, valid}, 32'd0);
        check32("t6_addr", imem_addr, 32'h0);
        rst = 1'b0; mem_lat = 0; #1;
        check32("t6_restart_req", {31'h0, imem_req}, 32'd1);
        check32("t6_restart_addr", imem_addr, 32'h0);
        branch_taken = 1'b1; branch_addr = 32'hFFFF_FFF8;
        step(); check_bubble("t6_br"); check32("t6_braddr", imem_addr, 32'hFFFF_FFF8);
        branch_taken = 1'b0;
        expect_entry(32'hFFFF_FFF8); expect_entry(32'hFFFF_FFFC);
        step(); check_entry("t6_eF8", 32'hFFFF_FFF8);
        step(); check_entry("t6_eFC", 32'hFFFF_FFFC);
        check32("t6_wrap_pcout", pc_out, 32'h0);
        check32("t6_wrap_addr", imem_addr, 32'h0);
        step(); check_entry("t6_e0", 32'h0);
        freeze = 1'b1;
        step(); step();

        check32("sb_drained", sb_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
